// File: rtl/ecc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_ctrl_pkg
// Description : Shared constants for the ECC operation sequencer. Holds the
//               opcode and codeword-width codes, the sequencer state
//               encoding and the width-to-noise-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_ctrl_pkg;

    // CTRL[1:0] opcodes; 2'b11 is illegal
    localparam logic [1:0] OP_ENC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_FULL = 2'b10;

    // CODEWORD_WIDTH[1:0] codes; 2'b11 is illegal
    localparam logic [1:0] W8  = 2'b00;
    localparam logic [1:0] W16 = 2'b01;
    localparam logic [1:0] W32 = 2'b10;

    // Sequencer state encoding
    typedef logic [2:0] state_t;
    localparam state_t IDLE     = 3'd0;
    localparam state_t CHECK    = 3'd1;
    localparam state_t ENC_REQ  = 3'd2;
    localparam state_t ENC_WAIT = 3'd3;
    localparam state_t DEC_REQ  = 3'd4;
    localparam state_t DEC_WAIT = 3'd5;
    localparam state_t DONE     = 3'd6;
    localparam state_t ERR      = 3'd7;

    // Bits of the codeword that noise may flip for a given width code.
    // The illegal code never reaches this function (aborted in CHECK).
    function automatic logic [31:0] width_mask(input logic [1:0] code);
        case (code)
            W8:      return 32'h0000_00FF;
            W16:     return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : ecc_wait_timer
// Description : Engine wait-cycle counter. Cleared before each WAIT state and
//               advanced on every WAIT cycle that passes without a done.
//               'expired' flags that the current WAIT cycle is the TIMEOUT-th
//               one, so the FSM aborts at the end of it unless done arrives.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               clear        - zero the counter
//               enable       - count one elapsed wait cycle
//               expired      - current wait cycle is the last one allowed
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // r_count holds the number of wait cycles already elapsed, so this
    // cycle is the TIMEOUT-th when it equals TIMEOUT-1.
    assign expired = (r_count == TO_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/ecc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ecc_op_sequencer
// Description : Runs one ECC operation per CTRL write. Snapshots the command,
//               drives the encoder/decoder through start/done handshakes,
//               injects masked noise for full-channel operations and returns
//               result, error count and status. One operation in flight.
// Ports       : clk, reset                 - clock, sync active-high reset
//               ctrl_ready, ctrl, data_in,
//               codeword_width, noise      - command from the register bank
//               enc_start/done/result      - encoder handshake
//               dec_start/done/result,
//               dec_num_of_errors          - decoder handshake
//               op_data, op_width          - operand/width to the engines
//               data_out, num_of_errors,
//               operation_done, busy, err,
//               overrun                    - status back to the APB side
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_op_sequencer
    import ecc_ctrl_pkg::*;
#(
    parameter int AMBA_WORD = 32,
    parameter int TIMEOUT   = 16,
    parameter int TO_W      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ctrl_ready,
    input  logic [AMBA_WORD-1:0] ctrl,
    input  logic [AMBA_WORD-1:0] data_in,
    input  logic [AMBA_WORD-1:0] codeword_width,
    input  logic [AMBA_WORD-1:0] noise,
    output logic                 enc_start,
    input  logic                 enc_done,
    input  logic [AMBA_WORD-1:0] enc_result,
    output logic                 dec_start,
    input  logic                 dec_done,
    input  logic [AMBA_WORD-1:0] dec_result,
    input  logic [1:0]           dec_num_of_errors,
    output logic [AMBA_WORD-1:0] op_data,
    output logic [1:0]           op_width,
    output logic [AMBA_WORD-1:0] data_out,
    output logic [1:0]           num_of_errors,
    output logic                 operation_done,
    output logic                 busy,
    output logic                 err,
    output logic                 overrun
);

    state_t               r_state;
    logic [1:0]           r_opcode;
    logic [1:0]           r_width;
    logic [AMBA_WORD-1:0] r_data;
    logic [AMBA_WORD-1:0] r_noise;
    logic                 r_enc_start;
    logic                 r_dec_start;
    logic [AMBA_WORD-1:0] r_op_data;
    logic [1:0]           r_op_width;
    logic [AMBA_WORD-1:0] r_data_out;
    logic [1:0]           r_num_err;
    logic                 r_op_done;
    logic                 r_busy;
    logic                 r_err;

    logic                 w_timer_clear;
    logic                 w_timer_en;
    logic                 w_expired;
    logic [AMBA_WORD-1:0] w_mask;
    logic                 w_unused;

    // Only the low two bits of CTRL and CODEWORD_WIDTH carry meaning
    assign w_unused = ^{ctrl[AMBA_WORD-1:2], codeword_width[AMBA_WORD-1:2]};

    assign w_mask = AMBA_WORD'(width_mask(r_width));

    // Counter is zeroed while requesting, so it starts at 0 on WAIT entry
    assign w_timer_clear = (r_state == ENC_REQ) || (r_state == DEC_REQ);
    assign w_timer_en    = ((r_state == ENC_WAIT) && !enc_done) ||
                           ((r_state == DEC_WAIT) && !dec_done);

    ecc_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_timer_clear),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_opcode    <= '0;
            r_width     <= '0;
            r_data      <= '0;
            r_noise     <= '0;
            r_enc_start <= 1'b0;
            r_dec_start <= 1'b0;
            r_op_data   <= '0;
            r_op_width  <= '0;
            r_data_out  <= '0;
            r_num_err   <= '0;
            r_op_done   <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Pulse outputs default low; set only on the entering transition
            r_enc_start <= 1'b0;
            r_dec_start <= 1'b0;
            r_op_done   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (ctrl_ready) begin
                        r_opcode <= ctrl[1:0];
                        r_width  <= codeword_width[1:0];
                        r_data   <= data_in;
                        r_noise  <= noise;
                        r_err    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= CHECK;
                    end
                end

                CHECK: begin
                    if ((r_opcode == 2'b11) || (r_width == 2'b11)) begin
                        r_state    <= ERR;
                        r_op_done  <= 1'b1;
                        r_err      <= 1'b1;
                        r_data_out <= '0;
                        r_num_err  <= 2'b11;
                    end else if (r_opcode == OP_DEC) begin
                        r_state     <= DEC_REQ;
                        r_dec_start <= 1'b1;
                        r_op_data   <= r_data;
                        r_op_width  <= r_width;
                    end else begin
                        r_state     <= ENC_REQ;
                        r_enc_start <= 1'b1;
                        r_op_data   <= r_data;
                        r_op_width  <= r_width;
                    end
                end

                ENC_REQ: r_state <= ENC_WAIT;

                ENC_WAIT: begin
                    // done takes priority over a simultaneous timeout
                    if (enc_done) begin
                        if (r_opcode == OP_ENC) begin
                            r_state    <= DONE;
                            r_op_done  <= 1'b1;
                            r_err      <= 1'b0;
                            r_data_out <= enc_result;
                            r_num_err  <= 2'b00;
                        end else begin
                            // Full channel: corrupt the codeword inside its width
                            r_state     <= DEC_REQ;
                            r_dec_start <= 1'b1;
                            r_op_data   <= enc_result ^ (r_noise & w_mask);
                        end
                    end else if (w_expired) begin
                        r_state    <= ERR;
                        r_op_done  <= 1'b1;
                        r_err      <= 1'b1;
                        r_data_out <= '0;
                        r_num_err  <= 2'b11;
                    end
                end

                DEC_REQ: r_state <= DEC_WAIT;

                DEC_WAIT: begin
                    if (dec_done) begin
                        r_state    <= DONE;
                        r_op_done  <= 1'b1;
                        r_err      <= 1'b0;
                        r_data_out <= dec_result;
                        r_num_err  <= dec_num_of_errors;
                    end else if (w_expired) begin
                        r_state    <= ERR;
                        r_op_done  <= 1'b1;
                        r_err      <= 1'b1;
                        r_data_out <= '0;
                        r_num_err  <= 2'b11;
                    end
                end

                DONE, ERR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign enc_start      = r_enc_start;
    assign dec_start      = r_dec_start;
    assign op_data        = r_op_data;
    assign op_width       = r_op_width;
    assign data_out       = r_data_out;
    assign num_of_errors  = r_num_err;
    assign operation_done = r_op_done;
    assign busy           = r_busy;
    assign err            = r_err;
    // Flags the dropped command in the same cycle it is presented
    assign overrun        = ctrl_ready && r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ecc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecc_op_sequencer
// Description : Scoreboard bench for ecc_op_sequencer. Commands are issued
//               with random operands and engine delays; expected results and
//               latencies come from a behavioural model and are queued, and a
//               monitor compares them on every operation_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_ready;
    logic [31:0] ctrl, data_in, codeword_width, noise;
    logic        enc_start, enc_done;
    logic [31:0] enc_result;
    logic        dec_start, dec_done;
    logic [31:0] dec_result;
    logic [1:0]  dec_num_of_errors;
    logic [31:0] op_data;
    logic [1:0]  op_width;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        operation_done, busy, err, overrun;

    ecc_op_sequencer #(
        .AMBA_WORD (32),
        .TIMEOUT   (16),
        .TO_W      (5)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ctrl_ready        (ctrl_ready),
        .ctrl              (ctrl),
        .data_in           (data_in),
        .codeword_width    (codeword_width),
        .noise             (noise),
        .enc_start         (enc_start),
        .enc_done          (enc_done),
        .enc_result        (enc_result),
        .dec_start         (dec_start),
        .dec_done          (dec_done),
        .dec_result        (dec_result),
        .dec_num_of_errors (dec_num_of_errors),
        .op_data           (op_data),
        .op_width          (op_width),
        .data_out          (data_out),
        .num_of_errors     (num_of_errors),
        .operation_done    (operation_done),
        .busy              (busy),
        .err               (err),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic [1:0]  ne;
        logic        err;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (operation_done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("data_out", data_out, mon_e.data);
                chk("num_of_errors", 32'(num_of_errors), 32'(mon_e.ne));
                chk("err", 32'(err), 32'(mon_e.err));
                chk("latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
            end
        end
    end

    // ---------------- engine models ----------------
    int          cfg_d_enc = 0, cfg_d_dec = 0;
    logic [31:0] cfg_enc_res = '0, cfg_dec_res = '0;
    logic [1:0]  cfg_dec_ne = '0;
    logic [31:0] exp_enc_op = '0, exp_dec_op = '0;
    logic [1:0]  exp_width = '0;
    int          enc_cnt = 0, dec_cnt = 0;
    int          enc_starts = 0, dec_starts = 0;

    always @(negedge clk) begin
        enc_done   = 1'b0;
        dec_done   = 1'b0;
        enc_result = $urandom();
        dec_result = $urandom();
        dec_num_of_errors = 2'($urandom_range(0, 3));
        if (enc_cnt > 0) begin
            enc_cnt--;
            if (enc_cnt == 0) begin
                enc_done   = 1'b1;
                enc_result = cfg_enc_res;
                if (busy) chk("enc_op_stable", op_data, exp_enc_op);
            end
        end
        if (dec_cnt > 0) begin
            dec_cnt--;
            if (dec_cnt == 0) begin
                dec_done          = 1'b1;
                dec_result        = cfg_dec_res;
                dec_num_of_errors = cfg_dec_ne;
                if (busy) chk("dec_op_stable", op_data, exp_dec_op);
            end
        end
        if (enc_start) begin
            enc_starts++;
            chk("enc_op_data", op_data, exp_enc_op);
            chk("enc_op_width", 32'(op_width), 32'(exp_width));
            enc_cnt = cfg_d_enc;
        end
        if (dec_start) begin
            dec_starts++;
            chk("dec_op_data", op_data, exp_dec_op);
            chk("dec_op_width", 32'(op_width), 32'(exp_width));
            dec_cnt = cfg_d_dec;
        end
    end

    // ---------------- reference model + stimulus ----------------
    // An engine delay d means done in the d-th wait cycle; 0 or >16 never
    // completes within the 16-cycle allowance.
    function automatic bit times_out(input int d);
        return (d == 0) || (d > 16);
    endfunction

    function automatic int pick_delay();
        int r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return 16;
        if (r == 2) return 17;
        return $urandom_range(1, 4);
    endfunction

    task automatic do_op(input logic [1:0] opc, input logic [1:0] wdt,
                         input logic [31:0] dat, input logic [31:0] nse,
                         input logic [31:0] eres, input logic [31:0] dres,
                         input logic [1:0] dne, input int de, input int dd,
                         input int ovr_at);
        exp_t        e;
        logic [31:0] mask;
        int          n_enc, n_dec, s0e, s0d, k;
        // Cycle budget: accept(1) + check(1); each engine = request(1) + d
        // wait cycles; final DONE/ERR state; abort after 16 wait cycles.
        mask = (wdt == 2'd0) ? 32'h0000_00FF : (wdt == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        e.data = 32'h0; e.ne = 2'b11; e.err = 1'b1; n_enc = 0; n_dec = 0;
        if (opc == 2'd3 || wdt == 2'd3) begin
            e.lat = 2;
        end else if (opc == 2'd0) begin
            n_enc = 1;
            if (times_out(de)) e.lat = 3 + 16;
            else begin e.lat = 3 + de; e.data = eres; e.ne = 2'b00; e.err = 1'b0; end
        end else if (opc == 2'd1) begin
            n_dec = 1;
            if (times_out(dd)) e.lat = 3 + 16;
            else begin e.lat = 3 + dd; e.data = dres; e.ne = dne; e.err = 1'b0; end
        end else begin
            n_enc = 1;
            if (times_out(de)) e.lat = 3 + 16;
            else begin
                n_dec = 1;
                if (times_out(dd)) e.lat = 4 + de + 16;
                else begin e.lat = 4 + de + dd; e.data = dres; e.ne = dne; e.err = 1'b0; end
            end
        end

        cfg_d_enc = de; cfg_d_dec = dd; cfg_enc_res = eres; cfg_dec_res = dres;
        cfg_dec_ne = dne; exp_width = wdt; exp_enc_op = dat;
        exp_dec_op = (opc == 2'd1) ? dat : (eres ^ (nse & mask));
        s0e = enc_starts; s0d = dec_starts;

        @(negedge clk);
        ctrl = $urandom(); ctrl[1:0] = opc;
        codeword_width = $urandom(); codeword_width[1:0] = wdt;
        data_in = dat; noise = nse; ctrl_ready = 1'b1;
        e.issue = cyc;
        sb.push_back(e);
        #1 chk("overrun_idle", 32'(overrun), 32'h0);

        @(negedge clk);
        ctrl_ready = 1'b0;
        ctrl = $urandom(); data_in = $urandom(); noise = $urandom(); codeword_width = $urandom();
        chk("err_clear_on_accept", 32'(err), 32'h0);
        chk("busy_after_accept", 32'(busy), 32'h1);

        k = 1;
        while (busy && k < 100) begin
            if (k == ovr_at) begin
                ctrl_ready = 1'b1;
                #1 chk("overrun_busy", 32'(overrun), 32'h1);
            end
            @(negedge clk);
            ctrl_ready = 1'b0;
            if (k == ovr_at) #1 chk("overrun_pulse_end", 32'(overrun), 32'h0);
            k++;
        end
        chk("op_completes", 32'(busy), 32'h0);
        chk("enc_start_count", 32'(enc_starts - s0e), 32'(n_enc));
        chk("dec_start_count", 32'(dec_starts - s0d), 32'(n_dec));
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    initial begin
        logic [1:0] opc, wdt;
        int         r, s0e;

        reset = 1'b1; ctrl_ready = 1'b0; ctrl = '0; data_in = '0;
        codeword_width = '0; noise = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(operation_done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_num_err", 32'(num_of_errors), 32'h0);
        chk("rst_enc_start", 32'(enc_start), 32'h0);
        chk("rst_dec_start", 32'(dec_start), 32'h0);
        chk("rst_op_data", op_data, 32'h0);
        chk("rst_op_width", 32'(op_width), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);

        // Directed cases
        do_op(2'd0, 2'd0, 32'h5A, 32'h0, 32'hA5, 32'h0, 2'd0, 2, 0, 0);
        do_op(2'd2, 2'd0, 32'h12, 32'h0000_0101, 32'hF0, 32'h12, 2'd1, 1, 1, 0);
        do_op(2'd3, 2'd0, 32'h33, 32'h0, 32'h0, 32'h0, 2'd0, 1, 1, 0);
        do_op(2'd0, 2'd3, 32'h44, 32'h0, 32'h0, 32'h0, 2'd0, 1, 1, 0);
        do_op(2'd1, 2'd1, 32'hBEEF, 32'h0, 32'h0, 32'h0, 2'd0, 1, 0, 0);
        do_op(2'd0, 2'd1, 32'h1234, 32'h0, 32'h9876, 32'h0, 2'd0, 1, 1, 0);
        do_op(2'd0, 2'd2, 32'hCAFE_F00D, 32'h0, 32'h0BAD_CAFE, 32'h0, 2'd0, 3, 0, 3);
        do_op(2'd1, 2'd2, 32'h0F0F, 32'h0, 32'h0, 32'h7777, 2'd2, 0, 16, 0);
        do_op(2'd1, 2'd2, 32'h0F0F, 32'h0, 32'h0, 32'h7777, 2'd2, 0, 17, 0);
        do_op(2'd2, 2'd1, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h1357_9BDF, 32'h55, 2'd2, 16, 3, 0);

        // Reset during ENC_WAIT: operation abandoned silently
        cfg_d_enc = 5; exp_enc_op = 32'h77; exp_width = 2'd1; cfg_enc_res = 32'h99;
        s0e = enc_starts;
        @(negedge clk);
        ctrl = 32'h0; codeword_width = 32'h1; data_in = 32'h77; ctrl_ready = 1'b1;
        @(negedge clk);
        ctrl_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(operation_done), 32'h0);
        chk("midrst_data_out", data_out, 32'h0);
        chk("midrst_num_err", 32'(num_of_errors), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        chk("midrst_op_data", op_data, 32'h0);
        repeat (8) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'h0);
        chk("post_rst_no_start", 32'(enc_starts - s0e), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r   = $urandom_range(0, 9);
            opc = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r   = $urandom_range(0, 9);
            wdt = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            do_op(opc, wdt, $urandom(), $urandom(), $urandom(), $urandom(),
                  2'($urandom_range(0, 2)), pick_delay(), pick_delay(),
                  $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ecc_op_sequencer.md
Name: ecc_op_sequencer

Overview:
Sequences one ECC operation per CTRL write, with one operation in flight at a time. It accepts the CTRL_ready pulse and the CTRL / DATA_IN / CODEWORD_WIDTH / NOISE values from the register bank, then drives the encoder and decoder engines through start/done handshakes. For full-channel operations it injects masked noise between encode and decode. It returns the result, the error count and status to the APB side.

Parameters:
AMBA_WORD, 32, register and datapath word width
TIMEOUT, 16, maximum wait cycles for an engine done before the operation aborts
TO_W, 5, timeout counter width (must satisfy 2^TO_W > TIMEOUT)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ctrl_ready  in  1  one-cycle pulse: CTRL register was written
ctrl  in  AMBA_WORD  bits[1:0] opcode: 00 encode, 01 decode, 10 full channel, 11 illegal
data_in  in  AMBA_WORD  operand
codeword_width  in  AMBA_WORD  bits[1:0]: 00 = 8 bits, 01 = 16 bits, 10 = 32 bits, 11 illegal
noise  in  AMBA_WORD  noise vector, full-channel only
enc_start  out  1  one-cycle encoder request
enc_done  in  1  encoder result valid
enc_result  in  AMBA_WORD  encoder codeword
dec_start  out  1  one-cycle decoder request
dec_done  in  1  decoder result valid
dec_result  in  AMBA_WORD  decoded data
dec_num_of_errors  in  2  decoder error count
op_data  out  AMBA_WORD  operand presented to the engine; held stable from start until done
op_width  out  2  width code presented to the engine
data_out  out  AMBA_WORD  operation result
num_of_errors  out  2  result error count; 11 = aborted
operation_done  out  1  one-cycle completion pulse
busy  out  1  operation in flight
err  out  1  last operation aborted; sticky until the next accepted command
overrun  out  1  one-cycle pulse: ctrl_ready arrived while busy

Behaviour:
- Reset: state IDLE; all outputs 0; snapshot registers 0; timeout counter 0.
- Reset mid-operation: the operation is abandoned; no operation_done; the engines see no further start.
- IDLE, ctrl_ready=1: snapshot opcode, width, data_in and noise, then go to CHECK. Later register writes do not affect the in-flight operation.
- busy is 1 in every state except IDLE.
- ctrl_ready while busy: command dropped, overrun=1 for that cycle, current operation unaffected.
- CHECK (1 cycle):
  - opcode 11 or width 11 -> ERR.
  - opcode 00 or 10 -> ENC_REQ.
  - opcode 01 -> DEC_REQ with op_data = snapshot data.
- ENC_REQ: enc_start=1, op_data = snapshot data, op_width = width; -> ENC_WAIT.
- ENC_WAIT, enc_done=1:
  - encode -> DONE with data_out = enc_result, num_of_errors = 00.
  - full channel -> DEC_REQ with op_data = enc_result XOR (noise AND width_mask).
- width_mask: 0x000000FF / 0x0000FFFF / 0xFFFFFFFF for codes 00 / 01 / 10.
- DEC_REQ: dec_start=1; -> DEC_WAIT.
- DEC_WAIT, dec_done=1: -> DONE with data_out = dec_result, num_of_errors = dec_num_of_errors.
- Timeout:
  - Counter clears on entry to each WAIT state and increments every WAIT cycle without done.
  - Reaching TIMEOUT -> ERR.
  - done in the same cycle as the count is reached: done wins.
- done sampling: engine done is sampled only in the matching WAIT state. done in REQ/IDLE/CHECK, or from the other engine, is ignored.
- DONE (1 cycle): operation_done=1, err cleared; -> IDLE.
- ERR (1 cycle): operation_done=1, err=1, data_out=0, num_of_errors=11; no further start issued; -> IDLE.
- data_out and num_of_errors hold until the next DONE/ERR. err also clears on the next accepted ctrl_ready.
- Latency, with engine done in its first WAIT cycle and ctrl_ready at cycle 0:
  - encode / decode: operation_done in cycle 4, busy=0 in cycle 5.
  - full channel: operation_done in cycle 6.
  - Each extra engine wait cycle adds 1.

Decomposition:
- Package ecc_ctrl_pkg:
  - opcode constants: OP_ENC, OP_DEC, OP_FULL
  - width codes: W8, W16, W32
  - state encoding: IDLE, CHECK, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, DONE, ERR
  - function width_mask(code)
- Sub-module ecc_wait_timer: clear/enable inputs, expired output, parameterised by TIMEOUT. Reused by the FSM for both WAIT states.

Test Plan:
- Encode, width 00, data 0x5A, encoder model returns 0xA5 with done 2 cycles after enc_start -> enc_start at cycle 2, data_out=0x000000A5, num_of_errors=00, operation_done at cycle 5, err=0.
- Full channel, width 00, data 0x12, noise 0x00000101, enc_result 0xF0 -> dec_start with op_data=0x000000F1. Decoder returns 0x12 with errors 01 -> data_out=0x12, num_of_errors=01.
- Opcode 11 (and separately width 11) -> ERR: operation_done at cycle 2, err=1, num_of_errors=11, enc_start and dec_start never asserted.
- Decode with dec_done never asserted -> after 16 DEC_WAIT cycles: operation_done, err=1, data_out=0. Next valid encode clears err.
- ctrl_ready pulsed in ENC_WAIT -> overrun=1 for one cycle; first operation completes with original data; no second operation starts.
- reset=1 during ENC_WAIT -> next cycle: busy=0, all outputs 0, no operation_done. A later enc_done is ignored.
